// File: rtl/cpu_inst_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, opcode constants and
// the rule deciding which opcodes are followed by an immediate byte.
package cpu_inst_fetch_pkg;

   localparam int unsigned ST_W = 2;

   // Fetch FSM state encodings
   localparam logic [ST_W-1:0] FETCH_IDLE     = 2'd0;
   localparam logic [ST_W-1:0] FETCH_OP_WAIT  = 2'd1;
   localparam logic [ST_W-1:0] FETCH_ARG_WAIT = 2'd2;
   localparam logic [ST_W-1:0] FETCH_DONE     = 2'd3;

   // Opcode map shared with cpu_control
   localparam logic [7:0] OP_NOP           = 8'h00;
   localparam logic [7:0] PATTERN_LDI_MASK = 8'hF0;
   localparam logic [7:0] PATTERN_LDI      = 8'h10;   // 0x1r: load immediate into r
   localparam logic [7:0] OP_JMP           = 8'h20;
   localparam logic [7:0] OP_JZ            = 8'h21;
   localparam logic [7:0] OP_JNZ           = 8'h22;
   localparam logic [7:0] OP_CALL          = 8'h23;
   localparam logic [7:0] OP_RET           = 8'h24;
   localparam logic [7:0] OP_OUT           = 8'h30;
   localparam logic [7:0] OP_HLT           = 8'hFF;

   // True when the opcode is followed by an immediate operand byte
   function automatic logic has_operand(input logic [7:0] op);
      return ((op & PATTERN_LDI_MASK) == PATTERN_LDI) ||
             (op == OP_JMP) || (op == OP_JZ) || (op == OP_JNZ) || (op == OP_CALL);
   endfunction

endpackage

// File: rtl/cpu_inst_fetch_timer.sv
// Memory wait-state counter for the fetch stage.
// Ports: clk, reset_n (async, active-low); clear restarts the count;
//        enable marks a cycle spent waiting on memory; expired is high in the
//        enabled cycle that would be the TIMEOUT-th consecutive wait.
module cpu_inst_fetch_timer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] count;

   // Expiry is judged on the current wait cycle so the fault lands on its closing edge
   assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

   // Wait counter; clear wins over enable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cpu_inst_fetch.sv
// Instruction fetch stage feeding cpu_control. On fetch_req it reads the
// opcode byte at pc and, for opcodes with an immediate, the following byte,
// over a variable-latency rd/ready memory handshake.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   fetch_req, flush, pc     request pulse, abort, opcode address
//   mem_addr, mem_rd         memory read address / request (held until ready)
//   mem_ready, mem_data      memory data valid / read data
//   opcode, operand          latched instruction bytes (operand 0 when none)
//   inst_valid               opcode/operand form a complete instruction
//   pc_inc                   one pulse per byte consumed
//   reset_cycle              one pulse when a new instruction is latched
//   busy                     fetch in progress
//   fault                    sticky memory timeout
module cpu_inst_fetch
   import cpu_inst_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] opcode,
   output logic [DATA_W-1:0] operand,
   output logic              inst_valid,
   output logic              pc_inc,
   output logic              reset_cycle,
   output logic              busy,
   output logic              fault
);

   logic [ST_W-1:0]   state, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_d;
   logic [DATA_W-1:0] opcode_d, operand_d;
   logic              mem_rd_d, inst_valid_d, pc_inc_d, reset_cycle_d, busy_d, fault_d;
   logic              timer_clear, timer_expired, beat;

   // Wait-state timer; counts only cycles with an outstanding, unanswered read
   cpu_inst_fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (mem_rd && !mem_ready),
      .expired (timer_expired)
   );

   // Next-state and next-output decode
   always_comb begin
      state_d       = state;
      addr_d        = addr_q;
      mem_addr_d    = mem_addr;
      mem_rd_d      = mem_rd;
      opcode_d      = opcode;
      operand_d     = operand;
      inst_valid_d  = inst_valid;
      fault_d       = fault;
      pc_inc_d      = 1'b0;
      reset_cycle_d = 1'b0;
      timer_clear   = 1'b0;
      beat          = mem_rd && mem_ready;

      if (flush) begin
         // Abort wins over everything, including a same-cycle ready or request
         state_d      = FETCH_IDLE;
         mem_rd_d     = 1'b0;
         inst_valid_d = 1'b0;
         timer_clear  = 1'b1;
      end else begin
         case (state)
            FETCH_IDLE: begin
               if (fetch_req) begin
                  addr_d       = pc;
                  mem_addr_d   = pc;
                  mem_rd_d     = 1'b1;
                  inst_valid_d = 1'b0;
                  timer_clear  = 1'b1;
                  state_d      = FETCH_OP_WAIT;
               end
            end
            FETCH_OP_WAIT: begin
               if (beat) begin
                  opcode_d    = mem_data;
                  pc_inc_d    = 1'b1;
                  mem_rd_d    = 1'b0;
                  timer_clear = 1'b1;
                  if (has_operand(8'(mem_data))) begin
                     mem_addr_d = addr_q + ADDR_W'(1);
                     state_d    = FETCH_ARG_WAIT;
                  end else begin
                     operand_d = '0;
                     state_d   = FETCH_DONE;
                  end
               end else if (timer_expired) begin
                  fault_d  = 1'b1;
                  mem_rd_d = 1'b0;
                  state_d  = FETCH_IDLE;
               end
            end
            FETCH_ARG_WAIT: begin
               // First cycle here has mem_rd low: the operand is its own transaction
               if (!mem_rd) begin
                  mem_rd_d = 1'b1;
               end else if (beat) begin
                  operand_d = mem_data;
                  pc_inc_d  = 1'b1;
                  mem_rd_d  = 1'b0;
                  state_d   = FETCH_DONE;
               end else if (timer_expired) begin
                  fault_d  = 1'b1;
                  mem_rd_d = 1'b0;
                  state_d  = FETCH_IDLE;
               end
            end
            FETCH_DONE: begin
               inst_valid_d  = 1'b1;
               reset_cycle_d = 1'b1;
               state_d       = FETCH_IDLE;
            end
            default: begin
               state_d = FETCH_IDLE;
            end
         endcase
      end

      busy_d = (state_d == FETCH_OP_WAIT) || (state_d == FETCH_ARG_WAIT);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= FETCH_IDLE;
         addr_q      <= '0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         opcode      <= '0;
         operand     <= '0;
         inst_valid  <= 1'b0;
         pc_inc      <= 1'b0;
         reset_cycle <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= state_d;
         addr_q      <= addr_d;
         mem_addr    <= mem_addr_d;
         mem_rd      <= mem_rd_d;
         opcode      <= opcode_d;
         operand     <= operand_d;
         inst_valid  <= inst_valid_d;
         pc_inc      <= pc_inc_d;
         reset_cycle <= reset_cycle_d;
         busy        <= busy_d;
         fault       <= fault_d;
      end
   end

endmodule
